// File: rtl/jc_link_pkg.sv
// Shared constants for the JC header link conditioner: pin map and 100 MHz timing defaults.
package jc_link_pkg;

  localparam int JC_W      = 5;
  localparam int JC_DIR_LO = 0;
  localparam int JC_DIR_HI = 1;
  localparam int JC_FIRE   = 2;
  localparam int JC_SEL    = 3;
  localparam int JC_RST    = 4;
  localparam int DIR_W     = 2;

  // 5 ms debounce and 100 ms reset hold at 100 MHz
  localparam int DEF_DEBOUNCE_CYCLES   = 500000;
  localparam int DEF_RESET_HOLD_CYCLES = 10000000;
  localparam int DEF_CNT_W             = 24;

endpackage

// File: rtl/jc_debounce.sv
// Two-flop synchroniser, active-low inversion and counter debounce for one header field.
module jc_debounce #(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] pin_n_i,
  output logic [WIDTH-1:0] stable_o
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] synced;

  assign synced = ~s2_q;

  // Whole vector is captured at the terminal cycle, so a multi-bit field never shows mixed codes.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == TERM) begin
      stable_d = synced;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q     <= '1;
      s2_q     <= '1;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= pin_n_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/jc_link_conditioner.sv
// Conditions the phone-link JC header lines into debounced levels, a gated fire pulse
// and a hold-qualified game-reset request for the control mux.
module jc_link_conditioner
  import jc_link_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int RESET_HOLD_CYCLES = DEF_RESET_HOLD_CYCLES,
  parameter int CNT_W             = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [JC_W-1:0]  jc_n,
  output logic [DIR_W-1:0] ctl_dir,
  output logic             ctl_fire,
  output logic             ctl_fire_pulse,
  output logic             ctl_phone_sel,
  output logic             ctl_game_reset,
  output logic             ctl_changed
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(RESET_HOLD_CYCLES);

  logic [DIR_W-1:0] dir_s;
  logic             fire_s, sel_s, rst_s;

  jc_debounce #(.WIDTH(DIR_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_dir (
    .clk_i(clk), .rst_i(reset), .pin_n_i(jc_n[JC_DIR_HI:JC_DIR_LO]), .stable_o(dir_s)
  );
  jc_debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_fire (
    .clk_i(clk), .rst_i(reset), .pin_n_i(jc_n[JC_FIRE]), .stable_o(fire_s)
  );
  jc_debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_sel (
    .clk_i(clk), .rst_i(reset), .pin_n_i(jc_n[JC_SEL]), .stable_o(sel_s)
  );
  jc_debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_rst (
    .clk_i(clk), .rst_i(reset), .pin_n_i(jc_n[JC_RST]), .stable_o(rst_s)
  );

  logic [DIR_W-1:0] dir_q;
  logic             fire_q, sel_q;
  logic             pulse_q, pulse_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             game_q, game_d;

  // Hold counter saturates so a long press keeps the request asserted without wrapping.
  always_comb begin
    pulse_d   = fire_s & ~fire_q & sel_s;
    changed_d = (dir_s != dir_q) | (fire_s != fire_q) | (sel_s != sel_q);
    hold_d    = '0;
    if (rst_s) begin
      hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
    end
    game_d = rst_s & (hold_d == HOLD_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q     <= '0;
      fire_q    <= 1'b0;
      sel_q     <= 1'b0;
      pulse_q   <= 1'b0;
      changed_q <= 1'b0;
      hold_q    <= '0;
      game_q    <= 1'b0;
    end else begin
      dir_q     <= dir_s;
      fire_q    <= fire_s;
      sel_q     <= sel_s;
      pulse_q   <= pulse_d;
      changed_q <= changed_d;
      hold_q    <= hold_d;
      game_q    <= game_d;
    end
  end

  assign ctl_dir        = dir_s;
  assign ctl_fire       = fire_s;
  assign ctl_phone_sel  = sel_s;
  assign ctl_fire_pulse = pulse_q;
  assign ctl_changed    = changed_q;
  assign ctl_game_reset = game_q;

endmodule

// File: tb/tb_jc_link_conditioner.sv
// Directed and randomized checks of jc_link_conditioner against an edge-by-edge behavioural model.
module tb_jc_link_conditioner;

  localparam int DB   = 4;
  localparam int HOLD = 16;
  localparam int CW   = 5;

  localparam logic [4:0] IDLE  = 5'h1f;
  localparam logic [4:0] M_SEL = 5'h08;
  localparam logic [4:0] M_FIR = 5'h04;
  localparam logic [4:0] M_RST = 5'h10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] jc_n;
  logic [1:0] ctl_dir;
  logic       ctl_fire, ctl_fire_pulse, ctl_phone_sel, ctl_game_reset, ctl_changed;

  jc_link_conditioner #(
    .DEBOUNCE_CYCLES(DB), .RESET_HOLD_CYCLES(HOLD), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .jc_n(jc_n),
    .ctl_dir(ctl_dir), .ctl_fire(ctl_fire), .ctl_fire_pulse(ctl_fire_pulse),
    .ctl_phone_sel(ctl_phone_sel), .ctl_game_reset(ctl_game_reset), .ctl_changed(ctl_changed)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: pins seen at the last two edges, per-field stable value and mismatch run length,
  // stable values after the last two edges, and how long debounced reset has been high.
  logic [4:0] p1, p2;
  int st[4], run[4], a1[4], a2[4];
  int hi_len;
  logic [1:0] e_dir;
  logic e_fire, e_sel, e_pulse, e_chg, e_game;

  int n_pulse, n_chg, n_dirchg;
  logic saw3, saw_game;
  logic [1:0] last_dir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [4:0] pin, input logic rst);
    logic [4:0] inv;
    int in_v[4];
    if (rst) begin
      p1 = '1; p2 = '1; hi_len = 0;
      for (int u = 0; u < 4; u++) begin
        st[u] = 0; run[u] = 0; a1[u] = 0; a2[u] = 0;
      end
      e_pulse = 0; e_chg = 0; e_game = 0;
    end else begin
      e_pulse = (a1[1] == 1) && (a2[1] == 0) && (a1[2] == 1);
      e_chg   = (a1[0] != a2[0]) || (a1[1] != a2[1]) || (a1[2] != a2[2]);
      e_game  = (a1[3] == 1) && (hi_len >= HOLD);
      inv = ~p2;
      in_v[0] = int'(inv[1:0]);
      in_v[1] = int'(inv[2]);
      in_v[2] = int'(inv[3]);
      in_v[3] = int'(inv[4]);
      // A field takes the synced value once it has disagreed for DB consecutive edges.
      for (int u = 0; u < 4; u++) begin
        run[u] = (in_v[u] != st[u]) ? run[u] + 1 : 0;
        if (run[u] == DB) begin
          st[u]  = in_v[u];
          run[u] = 0;
        end
      end
      p2 = p1; p1 = pin;
      a2 = a1; a1 = st;
      hi_len = (a1[3] == 1) ? hi_len + 1 : 0;
    end
    e_dir  = 2'(st[0]);
    e_fire = (st[1] == 1);
    e_sel  = (st[2] == 1);
  endtask

  task automatic cyc(input logic [4:0] pin, input logic rst = 1'b0);
    jc_n  = pin;
    reset = rst;
    @(posedge clk);
    model_edge(pin, rst);
    #1;
    chk("dir",   32'(ctl_dir),        32'(e_dir));
    chk("fire",  32'(ctl_fire),       32'(e_fire));
    chk("sel",   32'(ctl_phone_sel),  32'(e_sel));
    chk("pulse", 32'(ctl_fire_pulse), 32'(e_pulse));
    chk("chg",   32'(ctl_changed),    32'(e_chg));
    chk("game",  32'(ctl_game_reset), 32'(e_game));
    n_pulse += int'(ctl_fire_pulse);
    n_chg   += int'(ctl_changed);
    if (ctl_dir != last_dir) n_dirchg++;
    last_dir = ctl_dir;
    if (ctl_dir == 2'b11) saw3 = 1'b1;
    if (ctl_game_reset) saw_game = 1'b1;
  endtask

  initial begin
    logic [4:0] rp;
    int len;
    jc_n = IDLE; reset = 1'b1;
    n_pulse = 0; n_chg = 0; n_dirchg = 0; saw3 = 0; saw_game = 0; last_dir = 2'b00;
    p1 = '1; p2 = '1; hi_len = 0;

    for (int i = 0; i < 3; i++) cyc(IDLE, 1'b1);
    chk("rst_dir", 32'(ctl_dir), 0);
    chk("rst_game", 32'(ctl_game_reset), 0);

    // Phone select: exactly 6 edges, one change pulse
    n_chg = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc(IDLE & ~M_SEL);
      if (i == 5) chk("sel_early", 32'(ctl_phone_sel), 0);
    end
    chk("sel_at6", 32'(ctl_phone_sel), 1);
    for (int i = 0; i < 4; i++) cyc(IDLE & ~M_SEL);
    chk("sel_chg_once", n_chg, 1);

    // Fire glitch of 3 cycles is rejected, 10-cycle press gives one pulse
    n_pulse = 0;
    for (int i = 0; i < 3; i++) cyc(IDLE & ~(M_SEL | M_FIR));
    for (int i = 0; i < 10; i++) cyc(IDLE & ~M_SEL);
    chk("fire_glitch", 32'(ctl_fire), 0);
    chk("fire_glitch_pulse", n_pulse, 0);
    for (int i = 1; i <= 10; i++) begin
      cyc(IDLE & ~(M_SEL | M_FIR));
      if (i == 6) chk("fire_at6", 32'(ctl_fire), 1);
    end
    chk("fire_one_pulse", n_pulse, 1);
    for (int i = 0; i < 10; i++) cyc(IDLE & ~M_SEL);

    // Fire without phone select never pulses
    for (int i = 0; i < 10; i++) cyc(IDLE);
    n_pulse = 0;
    for (int i = 0; i < 15; i++) cyc(IDLE & ~M_FIR);
    chk("nosel_fire", 32'(ctl_fire), 1);
    chk("nosel_pulse", n_pulse, 0);
    for (int i = 0; i < 10; i++) cyc(IDLE);

    // Direction 00 -> 01 -> 10 atomically, then per-cycle toggling is ignored
    saw3 = 0; n_dirchg = 0;
    for (int i = 0; i < 10; i++) cyc(5'b11110);
    chk("dir_01", 32'(ctl_dir), 1);
    for (int i = 0; i < 10; i++) cyc(5'b11101);
    chk("dir_10", 32'(ctl_dir), 2);
    chk("dir_steps", n_dirchg, 2);
    for (int i = 0; i < 20; i++) cyc((i % 2 == 0) ? 5'b11110 : 5'b11101);
    chk("dir_toggle", 32'(ctl_dir), 2);
    chk("dir_no11", 32'(saw3), 0);
    for (int i = 0; i < 10; i++) cyc(IDLE);

    // Game reset hold, release, and a too-short hold
    for (int i = 0; i < 30; i++) cyc(IDLE & ~M_RST);
    chk("game_set", 32'(ctl_game_reset), 1);
    for (int i = 1; i <= 10; i++) begin
      cyc(IDLE);
      if (i == 6) chk("game_hold_release", 32'(ctl_game_reset), 1);
      if (i == 7) chk("game_clear", 32'(ctl_game_reset), 0);
    end
    saw_game = 0;
    for (int i = 0; i < 10; i++) cyc(IDLE & ~M_RST);
    for (int i = 0; i < 15; i++) cyc(IDLE);
    chk("game_short", 32'(saw_game), 0);

    // Reset in the middle of fire and hold counting, then full re-qualification
    for (int i = 0; i < 12; i++) cyc(IDLE & ~(M_SEL | M_RST));
    for (int i = 0; i < 3; i++) cyc(IDLE & ~(M_SEL | M_RST | M_FIR));
    cyc(IDLE & ~(M_SEL | M_RST | M_FIR), 1'b1);
    chk("mid_rst_sel", 32'(ctl_phone_sel), 0);
    chk("mid_rst_fire", 32'(ctl_fire), 0);
    for (int i = 1; i <= 30; i++) begin
      cyc(IDLE & ~(M_SEL | M_RST | M_FIR));
      if (i == 5) chk("requal_early", 32'(ctl_phone_sel), 0);
      if (i == 6) chk("requal_fire", 32'(ctl_fire), 1);
      if (i == 21) chk("requal_game_early", 32'(ctl_game_reset), 0);
      if (i == 22) chk("requal_game", 32'(ctl_game_reset), 1);
    end

    // Random segments with occasional resets
    for (int s = 0; s < 200; s++) begin
      rp  = 5'($urandom);
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) cyc(rp, ($urandom_range(0, 79) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
